// File: rtl/fifo_pkg.sv
// Shared FIFO constants and sizing helpers.
package fifo_pkg;

    localparam int DEF_DEPTH = 32;
    localparam int DEF_WIDTH = 8;

    // Occupancy counter needs one extra bit to represent DEPTH itself.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// Producer/consumer bus of the flagged synchronous FIFO; master drives requests, slave is the FIFO.
interface sync_fifo_flags_if
    import fifo_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH
);

    localparam int DW = occ_width(DEPTH);

    logic             CLEAR_N;
    logic             WRITE;
    logic             READ;
    logic [WIDTH-1:0] DATA_IN;
    logic [WIDTH-1:0] DATA_OUT;
    logic             F_FULL_N;
    logic             F_EMPTY_N;
    logic             F_AFULL_N;
    logic             F_AEMPTY_N;
    logic [DW-1:0]    USE_DW;
    logic             OVERFLOW;
    logic             UNDERFLOW;

    modport master (
        output CLEAR_N, WRITE, READ, DATA_IN,
        input  DATA_OUT, F_FULL_N, F_EMPTY_N, F_AFULL_N, F_AEMPTY_N,
               USE_DW, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  CLEAR_N, WRITE, READ, DATA_IN,
        output DATA_OUT, F_FULL_N, F_EMPTY_N, F_AFULL_N, F_AEMPTY_N,
               USE_DW, OVERFLOW, UNDERFLOW
    );

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one read port, read registered (REG_READ=1) or combinational.
// The registered read output zeroes on clr; the array itself is never reset.
module fifo_ram #(
    parameter int DEPTH    = 32,
    parameter int WIDTH    = 8,
    parameter bit REG_READ = 1'b1
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    generate
        if (REG_READ) begin : g_reg_read
            logic [WIDTH-1:0] rdata_q;

            // Read-before-write: a same-edge write to raddr returns the old word.
            always_ff @(posedge clk) begin
                if (clr) begin
                    rdata_q <= '0;
                end else if (re) begin
                    rdata_q <= mem[raddr];
                end
            end

            assign rdata = rdata_q;
        end else begin : g_comb_read
            logic unused_ctrl;

            assign unused_ctrl = re ^ clr;
            assign rdata       = mem[raddr];
        end
    endgenerate

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered full/empty/almost flags, occupancy count and sticky over/underflow.
// Read data 1 cycle after an accepted read (FWFT=0) or head shown directly (FWFT=1); excess requests are dropped and flagged.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    parameter bit FWFT     = 1'b0
) (
    input  logic CLOCK,
    input  logic RESET_N,
    sync_fifo_flags_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = occ_width(DEPTH);

    generate
        if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
            $error("sync_fifo_flags: DEPTH must be a power of two and at least 4");
        end
        if (AE_LEVEL >= AF_LEVEL) begin : g_bad_levels
            $error("sync_fifo_flags: AE_LEVEL must be below AF_LEVEL");
        end
    endgenerate

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [DW-1:0]    count;
    logic [DW-1:0]    count_nxt;
    logic             full_n;
    logic             empty_n;
    logic             afull_n;
    logic             aempty_n;
    logic             overflow;
    logic             underflow;
    logic             rd_ok;
    logic             wr_ok;
    logic             flush;
    logic [WIDTH-1:0] ram_rdata;

    assign flush = !RESET_N || !bus.CLEAR_N;

    // A full FIFO still takes a write when a read frees the head slot on the same edge.
    assign rd_ok = bus.READ && empty_n;
    assign wr_ok = bus.WRITE && (full_n || rd_ok);

    always_comb begin
        count_nxt = count;
        if (wr_ok && !rd_ok) begin
            count_nxt = count + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full_n    <= 1'b1;
            empty_n   <= 1'b0;
            afull_n   <= 1'b1;
            aempty_n  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count     <= count_nxt;
            full_n    <= (count_nxt != DW'(DEPTH));
            empty_n   <= (count_nxt != '0);
            afull_n   <= (int'(count_nxt) < AF_LEVEL);
            aempty_n  <= (int'(count_nxt) > AE_LEVEL);
            overflow  <= overflow  || (bus.WRITE && !wr_ok);
            underflow <= underflow || (bus.READ  && !rd_ok);
        end
    end

    fifo_ram #(
        .DEPTH    (DEPTH),
        .WIDTH    (WIDTH),
        .REG_READ (!FWFT)
    ) u_ram (
        .clk   (CLOCK),
        .clr   (flush),
        .we    (wr_ok && !flush),
        .waddr (wr_ptr),
        .wdata (bus.DATA_IN),
        .re    (rd_ok && !flush),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    generate
        if (FWFT) begin : g_fwft
            logic [WIDTH-1:0] last_q;

            // Keeps the most recently consumed word visible once the FIFO drains.
            always_ff @(posedge CLOCK) begin
                if (flush) begin
                    last_q <= '0;
                end else if (rd_ok) begin
                    last_q <= ram_rdata;
                end
            end

            assign bus.DATA_OUT = empty_n ? ram_rdata : last_q;
        end else begin : g_registered
            assign bus.DATA_OUT = ram_rdata;
        end
    endgenerate

    assign bus.F_FULL_N   = full_n;
    assign bus.F_EMPTY_N  = empty_n;
    assign bus.F_AFULL_N  = afull_n;
    assign bus.F_AEMPTY_N = aempty_n;
    assign bus.USE_DW     = count;
    assign bus.OVERFLOW   = overflow;
    assign bus.UNDERFLOW  = underflow;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags at DEPTH=32, WIDTH=8, FWFT=0 with hand-computed expectations.
module tb_sync_fifo_flags;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   wr_seq;
    int   rd_seq;

    sync_fifo_flags_if #(.DEPTH(32), .WIDTH(8)) bus ();

    sync_fifo_flags #(
        .DEPTH    (32),
        .WIDTH    (8),
        .AF_LEVEL (28),
        .AE_LEVEL (4),
        .FWFT     (1'b0)
    ) dut (
        .CLOCK   (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        bus.WRITE   = 1'b1;
        bus.DATA_IN = d;
        tick();
        bus.WRITE   = 1'b0;
    endtask

    task automatic rd();
        bus.READ = 1'b1;
        tick();
        bus.READ = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " data_out"},  32'(bus.DATA_OUT),   32'h0);
        check({tag, " use_dw"},    32'(bus.USE_DW),     32'd0);
        check({tag, " empty_n"},   32'(bus.F_EMPTY_N),  32'd0);
        check({tag, " aempty_n"},  32'(bus.F_AEMPTY_N), 32'd0);
        check({tag, " full_n"},    32'(bus.F_FULL_N),   32'd1);
        check({tag, " afull_n"},   32'(bus.F_AFULL_N),  32'd1);
        check({tag, " overflow"},  32'(bus.OVERFLOW),   32'd0);
        check({tag, " underflow"}, 32'(bus.UNDERFLOW),  32'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        bus.CLEAR_N = 1'b1;
        bus.WRITE   = 1'b0;
        bus.READ    = 1'b0;
        bus.DATA_IN = 8'h00;
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Basic ordering with 1-cycle read latency.
        for (int i = 1; i <= 10; i++) wr(8'(i));
        check("fill10 use_dw", 32'(bus.USE_DW), 32'd10);
        check("fill10 empty_n", 32'(bus.F_EMPTY_N), 32'd1);
        check("fill10 aempty_n", 32'(bus.F_AEMPTY_N), 32'd1);
        for (int i = 1; i <= 10; i++) begin
            rd();
            check("order data", 32'(bus.DATA_OUT), 32'(i));
        end
        check("drain use_dw", 32'(bus.USE_DW), 32'd0);
        check("drain empty_n", 32'(bus.F_EMPTY_N), 32'd0);
        tick();
        check("hold data", 32'(bus.DATA_OUT), 32'h0A);

        // Fill to full, checking every threshold crossing.
        for (int i = 0; i < 32; i++) begin
            wr(8'(8'h40 + i));
            check("fill use_dw", 32'(bus.USE_DW), 32'(i + 1));
            check("fill afull_n", 32'(bus.F_AFULL_N), 32'((i + 1) < 28));
            check("fill full_n", 32'(bus.F_FULL_N), 32'((i + 1) != 32));
            check("fill aempty_n", 32'(bus.F_AEMPTY_N), 32'((i + 1) > 4));
        end
        wr(8'hEE);
        check("ovf flag", 32'(bus.OVERFLOW), 32'd1);
        check("ovf use_dw", 32'(bus.USE_DW), 32'd32);
        check("ovf full_n", 32'(bus.F_FULL_N), 32'd0);

        // Simultaneous read+write while full.
        bus.READ    = 1'b1;
        bus.WRITE   = 1'b1;
        bus.DATA_IN = 8'hAA;
        tick();
        bus.READ    = 1'b0;
        bus.WRITE   = 1'b0;
        check("rw_full use_dw", 32'(bus.USE_DW), 32'd32);
        check("rw_full full_n", 32'(bus.F_FULL_N), 32'd0);
        check("rw_full data", 32'(bus.DATA_OUT), 32'h40);
        for (int i = 1; i < 32; i++) begin
            rd();
            check("full drain data", 32'(bus.DATA_OUT), 32'(8'h40 + i));
        end
        rd();
        check("rw_full 32nd", 32'(bus.DATA_OUT), 32'hAA);
        check("full drain empty_n", 32'(bus.F_EMPTY_N), 32'd0);
        check("ovf sticky", 32'(bus.OVERFLOW), 32'd1);
        check("no underflow yet", 32'(bus.UNDERFLOW), 32'd0);

        // Simultaneous read+write while empty: only the write lands.
        bus.READ    = 1'b1;
        bus.WRITE   = 1'b1;
        bus.DATA_IN = 8'h55;
        tick();
        bus.READ    = 1'b0;
        bus.WRITE   = 1'b0;
        check("rw_empty udf", 32'(bus.UNDERFLOW), 32'd1);
        check("rw_empty use_dw", 32'(bus.USE_DW), 32'd1);
        check("rw_empty data held", 32'(bus.DATA_OUT), 32'hAA);
        rd();
        check("rw_empty read", 32'(bus.DATA_OUT), 32'h55);
        rd();
        check("empty read held", 32'(bus.DATA_OUT), 32'h55);
        check("empty read use_dw", 32'(bus.USE_DW), 32'd0);

        // 40 entries through partial fill/drain so both pointers wrap.
        wr_seq = 0;
        rd_seq = 0;
        for (int i = 0; i < 25; i++) begin wr(8'(8'h80 + wr_seq)); wr_seq++; end
        for (int i = 0; i < 15; i++) begin
            rd();
            check("wrap data a", 32'(bus.DATA_OUT), 32'(8'h80 + rd_seq));
            rd_seq++;
        end
        for (int i = 0; i < 15; i++) begin wr(8'(8'h80 + wr_seq)); wr_seq++; end
        check("wrap use_dw", 32'(bus.USE_DW), 32'd25);
        for (int i = 0; i < 25; i++) begin
            rd();
            check("wrap data b", 32'(bus.DATA_OUT), 32'(8'h80 + rd_seq));
            rd_seq++;
        end
        check("wrap empty_n", 32'(bus.F_EMPTY_N), 32'd0);

        // Clear with 10 stored and sticky flags set; the write in that cycle is ignored.
        for (int i = 0; i < 10; i++) wr(8'(8'hC0 + i));
        check("pre-clear use_dw", 32'(bus.USE_DW), 32'd10);
        check("pre-clear ovf", 32'(bus.OVERFLOW), 32'd1);
        bus.CLEAR_N = 1'b0;
        bus.WRITE   = 1'b1;
        bus.DATA_IN = 8'h99;
        tick();
        bus.CLEAR_N = 1'b1;
        bus.WRITE   = 1'b0;
        check_reset_outputs("clear");
        wr(8'h33);
        rd();
        check("post-clear data", 32'(bus.DATA_OUT), 32'h33);

        // Reset in the middle of a write burst.
        bus.WRITE = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.DATA_IN = 8'(8'hD0 + i);
            tick();
        end
        check("burst use_dw", 32'(bus.USE_DW), 32'd6);
        rst_n = 1'b0;
        tick();
        bus.WRITE = 1'b0;
        check_reset_outputs("burst reset");
        rst_n = 1'b1;
        bus.READ    = 1'b1;
        bus.WRITE   = 1'b1;
        bus.DATA_IN = 8'h77;
        tick();
        bus.READ    = 1'b0;
        bus.WRITE   = 1'b0;
        check("post-reset udf", 32'(bus.UNDERFLOW), 32'd1);
        check("post-reset use_dw", 32'(bus.USE_DW), 32'd1);
        rd();
        check("post-reset data", 32'(bus.DATA_OUT), 32'h77);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
